boruss_mem_arbiter: RTL and testbench
=====================================

BORUSS_MEM_ARBITER -- requirements
Module: boruss_mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, shall set the number of cycles mem strobes are held per access (legal range 1-7).
REQ-002 Parameter STARVE_LIMIT, default 4, shall set the count of consecutive fetch-port losses that forces a fetch grant (legal range 1-15).
REQ-003 clk  input  1  clock; all state shall update on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch port request.
REQ-006 if_addr  input  8  fetch address.
REQ-007 if_rdata  output  8  fetch read data, valid with if_ack.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data port request.
REQ-010 d_we  input  1  data port write (1) / read (0).
REQ-011 d_addr  input  8  data address.
REQ-012 d_wdata  input  8  data write value.
REQ-013 d_rdata  output  8  data read value, valid with d_ack.
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 mem_addr  output  8  address to memory controller.
REQ-016 mem_wdata  output  8  write data to memory controller.
REQ-017 mem_we  output  1  memory write strobe.
REQ-018 mem_re  output  1  memory read strobe.
REQ-019 mem_rdata  input  8  memory read data, valid while mem_re high.
REQ-020 busy  output  1  high in any state other than IDLE.
REQ-021 owner  output  1  current/last grant: 0 = fetch, 1 = data.

Function
REQ-022 FSM states shall be IDLE, ACCESS, RESP; no other states reachable.
REQ-023 In IDLE with any request, the arbiter shall at the next edge enter ACCESS, latch winner, address, we and wdata into registers.
REQ-024 Arbitration: data port wins when both request, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-025 starve_cnt (4 bits) shall increment, saturating at STARVE_LIMIT, on each grant to data while if_req is high; shall clear on each grant to fetch.
REQ-026 In ACCESS, mem_addr/mem_wdata shall drive latched values; mem_re high for reads, mem_we high for data writes, for exactly WAIT_CYCLES cycles, then transition to RESP.
REQ-027 Fetch accesses shall always be reads; mem_we shall never assert for a fetch grant.
REQ-028 The read result shall be registered from mem_rdata on the last ACCESS cycle edge and presented on the winner's rdata during RESP.
REQ-029 In RESP the winner's ack shall be high for exactly one cycle; FSM shall then return to IDLE; the other ack shall stay low.
REQ-030 Request-to-ack latency from IDLE shall be WAIT_CYCLES+1 cycles; back-to-back throughput one access per WAIT_CYCLES+2 cycles.
REQ-031 Requesters shall hold req and operands until ack; changes to inputs after latch shall not affect the access in flight.
REQ-032 A request deasserted after grant shall not abort the access; the ack shall still pulse.
REQ-033 if_rdata/d_rdata shall hold their last value until the next read completion on that port.
REQ-034 Outside ACCESS, mem_we and mem_re shall be 0; mem_addr and mem_wdata shall hold last values.

Reset
REQ-035 Reset shall immediately force IDLE, abort any access, drive mem_we, mem_re, if_ack, d_ack, busy low, and clear starve_cnt, owner, mem_addr, mem_wdata, if_rdata, d_rdata to 0.
REQ-036 After reset deassertion, the first arbitration shall occur at the first rising edge with a request present.

Verification
REQ-037 WAIT_CYCLES=1; if_req, if_addr=0x10, mem_rdata=0xA5 -> mem_re one cycle with mem_addr=0x10, if_ack 2 cycles after req, if_rdata=0xA5, mem_we never high.
REQ-038 d_req, d_we=1, d_addr=0x80, d_wdata=0x3C -> mem_we one cycle, mem_addr=0x80, mem_wdata=0x3C, d_ack one cycle, if_ack stays 0.
REQ-039 if_req and d_req held continuously, STARVE_LIMIT=4 -> four data grants, then one fetch grant, pattern repeats; owner sequence 1,1,1,1,0.
REQ-040 WAIT_CYCLES=3, data read d_addr=0x42 -> mem_re high exactly 3 cycles, d_ack on 4th cycle after req.
REQ-041 Assert reset during ACCESS of a write -> mem_we drops same cycle, no ack issued, busy=0, starve_cnt=0; subsequent request served normally.
REQ-042 Drop d_req one cycle after grant -> access completes, d_ack pulses once, FSM returns to IDLE.

Source files
------------

// File: rtl/boruss_mem_arbiter.sv
// boruss_mem_arbiter
//   Two-port memory arbiter. An instruction-fetch port (read only) and a
//   data port (read/write) share one memory controller. Data wins ties
//   unless fetch has lost STARVE_LIMIT consecutive contested grants. Each
//   access holds the memory strobes for WAIT_CYCLES cycles. It then gives a
//   one-cycle ack to the winner.
//
// Ports
//   clk, reset                clock, asynchronous active-high reset
//   if_req/if_addr            fetch request and address
//   if_rdata/if_ack           fetch read data and completion pulse
//   d_req/d_we/d_addr/d_wdata data request, direction, address, write data
//   d_rdata/d_ack             data read data and completion pulse
//   mem_addr/mem_wdata        address and write data to the memory controller
//   mem_we/mem_re             memory write and read strobes
//   mem_rdata                 memory read data, valid while mem_re is high
//   busy                      high whenever the FSM is not in IDLE
//   owner                     current or last grant (0 = fetch, 1 = data)
module boruss_mem_arbiter #(
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_req,
  input  logic [7:0] if_addr,
  output logic [7:0] if_rdata,
  output logic       if_ack,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic [7:0] d_rdata,
  output logic       d_ack,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] WAIT_LAST  = 3'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state;
  logic [2:0] wait_cnt;    // remaining ACCESS cycles after the current one
  logic [3:0] starve_cnt;  // contested data grants since the last fetch grant
  logic       access_we;   // latched direction of the access in flight
  logic       fetch_wins;

  // Fetch wins when it is the only requester, or when it has been starved.
  assign fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_MAX));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 3'd0;
      starve_cnt <= 4'd0;
      access_we  <= 1'b0;
      owner      <= 1'b0;
      mem_addr   <= 8'd0;
      mem_wdata  <= 8'd0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      if_rdata   <= 8'd0;
      d_rdata    <= 8'd0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; they are set only on the ACCESS exit.
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state    <= ACCESS;
            wait_cnt <= WAIT_LAST;
            if (fetch_wins) begin
              owner      <= 1'b0;
              mem_addr   <= if_addr;
              access_we  <= 1'b0;
              mem_re     <= 1'b1;
              mem_we     <= 1'b0;
              starve_cnt <= 4'd0;
            end else begin
              owner     <= 1'b1;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              access_we <= d_we;
              mem_re    <= !d_we;
              mem_we    <= d_we;
              // Only a grant that fetch also wanted counts as a loss.
              if (if_req && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == 3'd0) begin
            state  <= RESP;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            // The read result is captured while mem_re is still high.
            if (!access_we) begin
              if (owner) d_rdata  <= mem_rdata;
              else       if_rdata <= mem_rdata;
            end
            if (owner) d_ack  <= 1'b1;
            else       if_ack <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boruss_mem_arbiter.sv
// tb_boruss_mem_arbiter
//   Directed bench for boruss_mem_arbiter. There are two instances: one
//   with WAIT_CYCLES=1 (dut) and one with WAIT_CYCLES=3 (dut3). They share
//   the stimulus. Inputs change and outputs are sampled on the falling edge.
module tb_boruss_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       if_req, d_req, d_we;
  logic [7:0] if_addr, d_addr, d_wdata, mem_rdata;

  logic [7:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic       if_ack, d_ack, mem_we, mem_re, busy, owner;

  logic [7:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
  logic       if_ack3, d_ack3, mem_we3, mem_re3, busy3, owner3;

  int n_checks = 0;
  int n_fails  = 0;

  logic exp_owner [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  boruss_mem_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  boruss_mem_arbiter #(.WAIT_CYCLES(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3), .if_ack(if_ack3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata3), .d_ack(d_ack3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_re(mem_re3),
    .mem_rdata(mem_rdata), .busy(busy3), .owner(owner3)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
    $display("check %-24s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 8'h00; d_addr = 8'h00; d_wdata = 8'h00; mem_rdata = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",     busy,     1'b0);
    check("rst_mem_re",   mem_re,   1'b0);
    check("rst_mem_we",   mem_we,   1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_owner",    owner,    1'b0);
    check("rst_if_ack",   if_ack,   1'b0);
    check("rst_d_rdata",  d_rdata,  8'h00);
    reset = 1'b0;

    // Fetch read, WAIT_CYCLES=1
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h10; mem_rdata = 8'hA5;
    @(negedge clk);
    check("f_busy",     busy,     1'b1);
    check("f_mem_re",   mem_re,   1'b1);
    check("f_mem_we",   mem_we,   1'b0);
    check("f_mem_addr", mem_addr, 8'h10);
    check("f_owner",    owner,    1'b0);
    check("f_ack_early", if_ack,  1'b0);
    @(negedge clk);
    check("f_if_ack",   if_ack,   1'b1);
    check("f_if_rdata", if_rdata, 8'hA5);
    check("f_re_off",   mem_re,   1'b0);
    check("f_we_off",   mem_we,   1'b0);
    check("f_d_ack",    d_ack,    1'b0);
    if_req = 1'b0;
    @(negedge clk);
    check("f_ack_pulse", if_ack,  1'b0);
    check("f_idle",     busy,     1'b0);
    check("f_hold_rd",  if_rdata, 8'hA5);

    // Data write, WAIT_CYCLES=1
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h80; d_wdata = 8'h3C;
    @(negedge clk);
    check("w_mem_we",    mem_we,    1'b1);
    check("w_mem_re",    mem_re,    1'b0);
    check("w_mem_addr",  mem_addr,  8'h80);
    check("w_mem_wdata", mem_wdata, 8'h3C);
    check("w_owner",     owner,     1'b1);
    @(negedge clk);
    check("w_d_ack",     d_ack,     1'b1);
    check("w_if_ack",    if_ack,    1'b0);
    check("w_we_off",    mem_we,    1'b0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("w_ack_pulse", d_ack,     1'b0);
    check("w_idle",      busy,      1'b0);
    check("w_hold_addr", mem_addr,  8'h80);
    check("w_hold_wd",   mem_wdata, 8'h3C);
    check("w_hold_ifrd", if_rdata,  8'hA5);

    // Starvation: both ports request continuously
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
    mem_rdata = 8'h77;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("s_owner_%0d", i), owner, exp_owner[i]);
      @(negedge clk);
      check($sformatf("s_d_ack_%0d", i),  d_ack,  exp_owner[i]);
      check($sformatf("s_if_ack_%0d", i), if_ack, !exp_owner[i]);
      @(negedge clk);
    end
    idle_inputs();

    // Data read, WAIT_CYCLES=3 (dut3)
    do_reset();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h42; mem_rdata = 8'h5A;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("w3_mem_re_%0d", i), mem_re3,   1'b1);
      check($sformatf("w3_addr_%0d", i),   mem_addr3, 8'h42);
      check($sformatf("w3_ack_%0d", i),    d_ack3,    1'b0);
    end
    @(negedge clk);
    check("w3_d_ack",   d_ack3,   1'b1);
    check("w3_d_rdata", d_rdata3, 8'h5A);
    check("w3_re_off",  mem_re3,  1'b0);
    d_req = 1'b0;
    @(negedge clk);
    check("w3_ack_pulse", d_ack3, 1'b0);

    // Asynchronous reset in the middle of a data write
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h01; d_req = 1'b1; d_we = 1'b1;
    d_addr = 8'h77; d_wdata = 8'h99;
    @(negedge clk);
    check("r_mem_we",  mem_we,         1'b1);
    check("r_starve1", dut.starve_cnt, 4'd1);
    #2 reset = 1'b1;
    #1;
    check("r_we_drop", mem_we,         1'b0);
    check("r_busy",    busy,           1'b0);
    check("r_starve0", dut.starve_cnt, 4'd0);
    check("r_addr0",   mem_addr,       8'h00);
    idle_inputs();
    @(negedge clk);
    check("r_no_dack", d_ack,  1'b0);
    check("r_no_iack", if_ack, 1'b0);
    reset = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h55; d_wdata = 8'h11;
    @(negedge clk);
    check("r2_mem_we",   mem_we,   1'b1);
    check("r2_mem_addr", mem_addr, 8'h55);
    @(negedge clk);
    check("r2_d_ack",    d_ack,    1'b1);
    idle_inputs();
    @(negedge clk);

    // Request dropped one cycle after grant
    do_reset();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h21; mem_rdata = 8'hC3;
    @(negedge clk);
    check("x_mem_re", mem_re, 1'b1);
    d_req = 1'b0;
    @(negedge clk);
    check("x_d_ack",   d_ack,   1'b1);
    check("x_d_rdata", d_rdata, 8'hC3);
    @(negedge clk);
    check("x_ack_off", d_ack,   1'b0);
    check("x_idle",    busy,    1'b0);
    @(negedge clk);
    check("x_stay",    busy,    1'b0);
    check("x_no_ack",  d_ack,   1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
